// File: rtl/neo_pkg.sv
// neo_pkg: shared width helpers, default parameters and default-width types for the NEO detector
package neo_pkg;
  localparam int N_DEF = 16;
  localparam int C_DEF = 4;
  localparam int K_DEF = 1;
  localparam int REFRACT_DEF = 8;
  function automatic int cw_f(input int c);
    return c > 1 ? $clog2(c) : 1;
  endfunction
  function automatic int ew_f(input int n);
    return 2 * n + 1;
  endfunction
  typedef logic signed [N_DEF-1:0] sample_t;
  typedef logic signed [ew_f(N_DEF)-1:0] energy_t;
  typedef struct packed {
    logic valid;
    logic [cw_f(C_DEF)-1:0] chan;
    logic signed [2*N_DEF-1:0] sq;
    logic signed [2*N_DEF-1:0] xp;
  } stage1_t;
endpackage

// File: rtl/neo_chan_history.sv
// neo_chan_history: per-channel (2K+1)-deep sample history with fill counters and stage-0 issue register
module neo_chan_history #(
  parameter int N = 16,
  parameter int C = 4,
  parameter int K = 1,
  parameter int CW = 2
) (
  input logic Clk,
  input logic reset,
  input logic en,
  input logic we,
  input logic [CW-1:0] chan,
  input logic signed [N-1:0] data,
  output logic issue,
  output logic [CW-1:0] issue_chan,
  output logic signed [N-1:0] x_new,
  output logic signed [N-1:0] x_mid,
  output logic signed [N-1:0] x_old
);
  localparam int D = 2 * K + 1;
  localparam int FW = $clog2(D + 1);
  logic signed [N-1:0] hist [C][D];
  logic [FW-1:0] fill [C];
  assign x_new = hist[issue_chan][0];
  assign x_mid = hist[issue_chan][K];
  assign x_old = hist[issue_chan][2*K];
  always_ff @(posedge Clk)
    if (reset) begin
      for (int i = 0; i < C; i++) begin
        fill[i] <= '0;
        for (int j = 0; j < D; j++) hist[i][j] <= '0;
      end
      issue <= 1'b0;
      issue_chan <= '0;
    end else if (en) begin
      issue <= we && fill[chan] >= FW'(D - 1);
      issue_chan <= chan;
      if (we) begin
        hist[chan][0] <= data;
        for (int j = 1; j < D; j++) hist[chan][j] <= hist[chan][j-1];
        fill[chan] <= fill[chan] == FW'(D) ? fill[chan] : fill[chan] + FW'(1);
      end
    end
endmodule

// File: rtl/neo_mc_detector.sv
// neo_mc_detector: multi-channel lag-K NEO engine with threshold spike detection and refractory suppression
module neo_mc_detector import neo_pkg::*; #(
  parameter int N = N_DEF,
  parameter int C = C_DEF,
  parameter int K = K_DEF,
  parameter int REFRACT = REFRACT_DEF,
  localparam int CW = cw_f(C),
  localparam int EW = ew_f(N)
) (
  input logic Clk,
  input logic reset,
  input logic in_valid,
  output logic in_ready,
  input logic signed [N-1:0] in_data,
  input logic [CW-1:0] in_chan,
  input logic signed [EW-1:0] thr,
  output logic out_valid,
  input logic out_ready,
  output logic signed [EW-1:0] out_energy,
  output logic [CW-1:0] out_chan,
  output logic out_spike
);
  localparam int RW = REFRACT > 0 ? $clog2(REFRACT + 1) : 1;
  typedef struct packed {
    logic valid;
    logic [CW-1:0] chan;
    logic signed [2*N-1:0] sq;
    logic signed [2*N-1:0] xp;
  } s1_t;
  logic en, we, issue, spike;
  logic [CW-1:0] issue_chan;
  logic signed [N-1:0] x_new, x_mid, x_old;
  logic signed [2*N-1:0] sq, xp;
  logic signed [EW-1:0] energy;
  logic [RW-1:0] refr [C];
  s1_t s1;
  assign en = !out_valid || out_ready;
  assign in_ready = en;
  assign we = in_valid && en && 32'(in_chan) < C;
  neo_chan_history #(.N(N), .C(C), .K(K), .CW(CW)) u_hist (
    .Clk(Clk),
    .reset(reset),
    .en(en),
    .we(we),
    .chan(in_chan),
    .data(in_data),
    .issue(issue),
    .issue_chan(issue_chan),
    .x_new(x_new),
    .x_mid(x_mid),
    .x_old(x_old)
  );
  always_comb begin
    sq = x_mid * x_mid;
    xp = x_new * x_old;
    energy = EW'($signed(s1.sq)) - EW'($signed(s1.xp));
    spike = energy > thr && refr[s1.chan] == '0;
  end
  always_ff @(posedge Clk)
    if (reset) s1 <= '0;
    else if (en) s1 <= '{valid: issue, chan: issue_chan, sq: sq, xp: xp};
  always_ff @(posedge Clk)
    if (reset) begin
      out_valid <= 1'b0;
      out_energy <= '0;
      out_chan <= '0;
      out_spike <= 1'b0;
      for (int i = 0; i < C; i++) refr[i] <= '0;
    end else if (en) begin
      out_valid <= s1.valid;
      if (s1.valid) begin
        out_energy <= energy;
        out_chan <= s1.chan;
        out_spike <= spike;
        refr[s1.chan] <= spike ? RW'(REFRACT) : refr[s1.chan] - RW'(refr[s1.chan] != '0);
      end
    end
endmodule

// File: tb/tb_neo_mc_detector.sv
// tb_neo_mc_detector: directed and randomized self-checking bench for neo_mc_detector
module tb_neo_mc_detector;
  localparam int MR = 2;
  typedef struct {int chan; longint energy; bit spike;} res_t;
  logic Clk = 0, reset = 1;
  logic in_valid = 0, out_ready = 1, in_ready, out_valid, out_spike;
  logic signed [15:0] in_data = 0;
  logic [1:0] in_chan = 0, out_chan;
  logic signed [32:0] thr = 0, out_energy;
  logic b_in_valid = 0, b_out_ready = 1, b_in_ready, b_out_valid, b_out_spike;
  logic signed [15:0] b_in_data = 0;
  logic [1:0] b_in_chan = 0, b_out_chan;
  logic signed [32:0] b_thr = 0, b_out_energy;
  int checks = 0, failures = 0;
  res_t obs[$], exp_q[$];
  int xs[3][$];
  int mrefr[3];
  always #5 Clk = ~Clk;
  neo_mc_detector #(.N(16), .C(3), .K(1), .REFRACT(MR)) dut (
    .Clk(Clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_chan(in_chan), .thr(thr), .out_valid(out_valid), .out_ready(out_ready),
    .out_energy(out_energy), .out_chan(out_chan), .out_spike(out_spike)
  );
  neo_mc_detector #(.N(16), .C(4), .K(2), .REFRACT(8)) dut2 (
    .Clk(Clk), .reset(reset), .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
    .in_chan(b_in_chan), .thr(b_thr), .out_valid(b_out_valid), .out_ready(b_out_ready),
    .out_energy(b_out_energy), .out_chan(b_out_chan), .out_spike(b_out_spike)
  );
  function automatic void model_accept(input int ch, input int d);
    int n;
    longint e;
    bit s;
    xs[ch].push_back(d);
    n = xs[ch].size();
    if (n >= 3) begin
      e = longint'(xs[ch][n-2]) * xs[ch][n-2] - longint'(xs[ch][n-1]) * xs[ch][n-3];
      s = e > longint'(thr) && mrefr[ch] == 0;
      mrefr[ch] = s ? MR : (mrefr[ch] > 0 ? mrefr[ch] - 1 : 0);
      exp_q.push_back('{ch, e, s});
    end
  endfunction
  task automatic cycle(input bit v, input int ch, input int d, input bit ordy);
    bit acc, take;
    in_valid = v;
    in_chan = ch[1:0];
    in_data = d[15:0];
    out_ready = ordy;
    #4;
    acc = in_valid && in_ready;
    take = out_valid && out_ready;
    if (take) obs.push_back('{int'(out_chan), longint'(out_energy), out_spike});
    if (acc && ch < 3) model_accept(ch, d);
    @(posedge Clk);
    #1;
  endtask
  task automatic drain(input int n);
    repeat (n) cycle(0, 0, 0, 1);
  endtask
  task automatic do_reset();
    reset = 1;
    in_valid = 0;
    b_in_valid = 0;
    @(posedge Clk);
    #1;
    reset = 0;
    obs.delete();
    exp_q.delete();
    for (int c = 0; c < 3; c++) begin
      xs[c].delete();
      mrefr[c] = 0;
    end
  endtask
  task automatic test_reset();
    reset = 1;
    in_valid = 0;
    out_ready = 0;
    repeat (2) @(posedge Clk);
    #1;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
    checks++; if (out_energy !== 33'sd0) begin failures++; $display("FAIL reset_energy got=%0d want=0", out_energy); end
    checks++; if (out_chan !== 2'd0 || out_spike !== 1'b0) begin failures++; $display("FAIL reset_chan_spike got=%0d/%b want=0/0", out_chan, out_spike); end
    checks++; if (b_out_valid !== 1'b0) begin failures++; $display("FAIL reset_b_out_valid got=%b want=0", b_out_valid); end
    do_reset();
  endtask
  task automatic test_basic();
    do_reset();
    thr = 1000;
    cycle(1, 0, 1, 1);
    cycle(1, 0, 2, 1);
    drain(3);
    checks++; if (obs.size() != 0) begin failures++; $display("FAIL basic_warmup got=%0d results want=0", obs.size()); end
    cycle(1, 0, 3, 1);
    cycle(0, 0, 0, 1);
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL basic_latency_early got=%b want=0", out_valid); end
    cycle(0, 0, 0, 1);
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL basic_latency got=%b want=1", out_valid); end
    drain(3);
    checks++;
    if (obs.size() != 1) begin failures++; $display("FAIL basic_count got=%0d want=1", obs.size()); end
    else if (obs[0].energy != 1 || obs[0].chan != 0 || obs[0].spike != 0) begin
      failures++; $display("FAIL basic_result got=%0d/%0d/%0d want=1/0/0", obs[0].energy, obs[0].chan, obs[0].spike);
    end
  endtask
  task automatic test_refractory();
    int ds[7] = '{0, 100, 0, 100, 0, 100, 0};
    longint ee[5] = '{10000, -10000, 10000, -10000, 10000};
    bit es[5] = '{1, 0, 0, 0, 1};
    do_reset();
    thr = 5000;
    for (int i = 0; i < 7; i++) cycle(1, 1, ds[i], 1);
    drain(5);
    checks++; if (obs.size() != 5) begin failures++; $display("FAIL refr_count got=%0d want=5", obs.size()); end
    for (int i = 0; i < 5 && i < obs.size(); i++) begin
      checks++;
      if (obs[i].energy != ee[i] || obs[i].spike != es[i] || obs[i].chan != 1) begin
        failures++;
        $display("FAIL refr_result[%0d] got=%0d/%0d/%0d want=%0d/%0d/1", i, obs[i].energy, obs[i].spike, obs[i].chan, ee[i], es[i]);
      end
    end
  endtask
  task automatic test_interleave();
    int cs[8] = '{0, 1, 3, 0, 1, 0, 3, 1};
    int ds[8] = '{5, -3, 77, 5, 4, 5, -9, -3};
    do_reset();
    thr = 1000;
    for (int i = 0; i < 8; i++) cycle(1, cs[i], ds[i], 1);
    drain(5);
    checks++;
    if (obs.size() != 2) begin failures++; $display("FAIL inter_count got=%0d want=2", obs.size()); end
    else begin
      if (obs[0].chan != 0 || obs[0].energy != 0) begin failures++; $display("FAIL inter_ch0 got=%0d/%0d want=0/0", obs[0].chan, obs[0].energy); end
      checks++;
      if (obs[1].chan != 1 || obs[1].energy != 7) begin failures++; $display("FAIL inter_ch1 got=%0d/%0d want=1/7", obs[1].chan, obs[1].energy); end
    end
  endtask
  task automatic test_backpressure();
    longint ee[4] = '{14, -24, 43, -54};
    do_reset();
    thr = 1000;
    cycle(1, 2, 1, 1);
    cycle(1, 2, 4, 1);
    cycle(1, 2, 2, 1);
    cycle(1, 2, 7, 0);
    cycle(1, 2, 3, 0);
    checks++; if (out_valid !== 1'b1 || out_energy !== 33'sd14) begin failures++; $display("FAIL bp_first got=%b/%0d want=1/14", out_valid, out_energy); end
    for (int i = 0; i < 5; i++) begin
      cycle(1, 2, 9, 0);
      checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_energy !== 33'sd14 || out_chan !== 2'd2) begin
        failures++;
        $display("FAIL bp_hold[%0d] got ready=%b valid=%b energy=%0d chan=%0d want 0/1/14/2", i, in_ready, out_valid, out_energy, out_chan);
      end
    end
    cycle(1, 2, 9, 1);
    drain(6);
    checks++; if (obs.size() != 4) begin failures++; $display("FAIL bp_count got=%0d want=4", obs.size()); end
    for (int i = 0; i < 4 && i < obs.size(); i++) begin
      checks++;
      if (obs[i].energy != ee[i] || obs[i].chan != 2) begin
        failures++; $display("FAIL bp_result[%0d] got=%0d/%0d want=%0d/2", i, obs[i].energy, obs[i].chan, ee[i]);
      end
    end
  endtask
  task automatic test_reset_midstream();
    do_reset();
    thr = 1000;
    cycle(1, 0, 50, 1);
    cycle(1, 0, 60, 1);
    cycle(1, 1, 1, 1);
    cycle(1, 1, 2, 1);
    cycle(1, 1, 3, 1);
    reset = 1;
    in_valid = 0;
    for (int i = 0; i < 2; i++) begin
      @(posedge Clk);
      #1;
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL midreset_valid[%0d] got=%b want=0", i, out_valid); end
    end
    reset = 0;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL midreset_ready got=%b want=1", in_ready); end
    cycle(1, 0, 7, 1);
    cycle(1, 0, 1, 1);
    cycle(1, 0, 7, 1);
    drain(5);
    checks++;
    if (obs.size() != 1) begin failures++; $display("FAIL midreset_count got=%0d want=1", obs.size()); end
    else if (obs[0].energy != -48 || obs[0].chan != 0) begin
      failures++; $display("FAIL midreset_result got=%0d/%0d want=-48/0", obs[0].energy, obs[0].chan);
    end
  endtask
  task automatic test_k2_extremes();
    int s[5] = '{32767, 0, -32768, 0, -32768};
    bit early, seen;
    do_reset();
    b_thr = 33'sd2147450880;
    b_out_ready = 1;
    early = 0;
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      b_in_valid = 1;
      b_in_chan = 2'd3;
      b_in_data = s[i][15:0];
      @(posedge Clk);
      #1;
      early |= b_out_valid;
    end
    b_in_valid = 0;
    repeat (3) begin
      @(posedge Clk);
      #1;
      early |= b_out_valid;
    end
    checks++; if (early) begin failures++; $display("FAIL k2_warmup got result want none"); end
    b_in_valid = 1;
    b_in_data = s[4][15:0];
    @(posedge Clk);
    #1;
    b_in_valid = 0;
    for (int i = 0; i < 6 && !seen; i++) begin
      @(negedge Clk);
      seen = b_out_valid;
    end
    checks++;
    if (!seen) begin failures++; $display("FAIL k2_timeout got no result want one"); end
    else if (b_out_energy !== 33'sd2147450880 || b_out_chan !== 2'd3 || b_out_spike !== 1'b0) begin
      failures++; $display("FAIL k2_result got=%0d/%0d/%b want=2147450880/3/0", b_out_energy, b_out_chan, b_out_spike);
    end
    @(posedge Clk);
    #1;
  endtask
  task automatic test_random();
    int d, ch, n;
    do_reset();
    thr = 20000;
    for (int i = 0; i < 800; i++) begin
      ch = $urandom_range(0, 3);
      d = ($urandom_range(0, 7) == 0) ? int'($signed(16'($urandom))) : int'($urandom_range(0, 800)) - 400;
      cycle($urandom_range(0, 3) != 0, ch, d, $urandom_range(0, 3) != 0);
    end
    drain(12);
    checks++; if (obs.size() != exp_q.size()) begin failures++; $display("FAIL rand_count got=%0d want=%0d", obs.size(), exp_q.size()); end
    n = obs.size() < exp_q.size() ? obs.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      checks++;
      if (obs[i].chan != exp_q[i].chan || obs[i].energy != exp_q[i].energy || obs[i].spike != exp_q[i].spike) begin
        failures++;
        $display("FAIL rand_result[%0d] got=%0d/%0d/%0d want=%0d/%0d/%0d", i, obs[i].chan, obs[i].energy, obs[i].spike,
                 exp_q[i].chan, exp_q[i].energy, exp_q[i].spike);
      end
    end
  endtask
  initial begin
    test_reset();
    test_basic();
    test_refractory();
    test_interleave();
    test_backpressure();
    test_reset_midstream();
    test_k2_extremes();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
  initial begin
    #2000000;
    $display("FAIL watchdog expired before summary");
    $fatal(1, "watchdog");
  end
endmodule
